// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector (MSB first) with run-time overlap mode,
// sample enable, synchronous clear, match counter and fill/progress output.
// Optional macro SEQ_DET_SAT_CNT_EN: saturating match counter (default wraps).
module seq_det_param #(
  parameter int unsigned PAT_W   = 4,
  parameter logic [31:0] PATTERN = 32'b1010,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned FILL_W = $clog2(PAT_W + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In,
  input  logic              En,
  input  logic              Overlap,
  input  logic              Clr,
  output logic              OP,
  output logic [CNT_W-1:0]  Match_cnt,
  output logic [FILL_W-1:0] State
);

  localparam logic [PAT_W-1:0]  PAT       = PATTERN[PAT_W-1:0];
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [PAT_W-1:0]  nxt_c;
  logic              hit_c;

  assign nxt_c = {hist_q[PAT_W-2:0], In};
  assign hit_c = (fill_q >= FILL_LAST) && (nxt_c == PAT);

  // Next-state: clear beats enable; a non-overlapping hit restarts the history.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    op_d   = 1'b0;
    if (Clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (En) begin
      if (hit_c) begin
        op_d = 1'b1;
`ifdef SEQ_DET_SAT_CNT_EN
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`else
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (Overlap) begin
          hist_d = nxt_c;
          fill_d = FILL_FULL;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = nxt_c;
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      op_q   <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  assign OP        = op_q;
  assign Match_cnt = cnt_q;
  assign State     = fill_q;

endmodule
